hazard_sequencer: RTL

- Pipeline sequencing controller for the five-stage MIPS datapath. It consumes decoded control fields (PCSrc, dREN/dWEN, RegWr, RegDst) as they travel down the pipe, plus cache hit strobes.
- It drives per-latch enable and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- It resolves load-use hazards, taken branch/jump redirects, instruction and data cache misses, and halt.
- It keeps saturating stall and flush counters for performance reporting.

---
 rtl/control_unit_pkg.sv | 21 ++
 rtl/cpu_types_pkg.sv | 8 +
 rtl/hazard_sequencer_if.sv | 48 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_sequencer.sv | 123 ++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Decoded control-field types carried down the pipe, plus the sequencer state set.
package control_unit_pkg;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    RSEL_RT, RSEL_RD, RSEL_R31
  } regsel_t;

  typedef enum logic [1:0] {
    PCS_NEXT, PCS_BR, PCS_JUMP, PCS_JR
  } pcsrc_t;

  typedef enum logic [1:0] {
    RUN, MEM_WAIT, HALTED
  } seq_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types for the five-stage MIPS datapath.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-control bundle between the hazard sequencer and the datapath latches.
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);

  logic                      ihit;
  logic                      dhit;
  cpu_types_pkg::regbits_t   id_rs;
  cpu_types_pkg::regbits_t   id_rt;
  logic                      ex_dREN;
  logic                      ex_RegWr;
  cpu_types_pkg::regbits_t   ex_RegDst;
  control_unit_pkg::pcsrc_t  ex_PCSrc;
  logic                      ex_cond;
  logic                      mem_dREN;
  logic                      mem_dWEN;
  logic                      mem_halt;

  logic                      pc_en;
  logic                      ifid_en;
  logic                      idex_en;
  logic                      exmem_en;
  logic                      memwb_en;
  logic                      ifid_flush;
  logic                      idex_flush;
  logic                      exmem_flush;
  logic                      memwb_flush;
  logic                      halted;
  logic [CNT_W-1:0]          stall_cycles;
  logic [CNT_W-1:0]          flush_count;

  modport hs (
    input  ihit, dhit, id_rs, id_rt, ex_dREN, ex_RegWr, ex_RegDst, ex_PCSrc,
           ex_cond, mem_dREN, mem_dWEN, mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles, flush_count
  );

  modport tb (
    output ihit, dhit, id_rs, id_rt, ex_dREN, ex_RegWr, ex_RegDst, ex_PCSrc,
           ex_cond, mem_dREN, mem_dWEN, mem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles, flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: latch enables/flushes for load-use, redirect,
// cache misses and halt, plus saturating stall/flush performance counters.
module hazard_sequencer
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic             CLK,
  input logic             RST,
  hazard_sequencer_if.hs  bus
);

  localparam logic [1:0] S_RUN      = 2'(RUN);
  localparam logic [1:0] S_MEM_WAIT = 2'(MEM_WAIT);
  localparam logic [1:0] S_HALTED   = 2'(HALTED);

  logic [1:0] state_q, state_d;
  logic       pend_q, pend_d;

  logic redirect, loaduse, dmiss, ifetch_ok;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic halted, stall_inc, flush_inc;

  assign redirect  = (bus.ex_PCSrc == PCS_JUMP) || (bus.ex_PCSrc == PCS_JR) ||
                     ((bus.ex_PCSrc == PCS_BR) && bus.ex_cond);
  assign loaduse   = bus.ex_dREN && bus.ex_RegWr && (bus.ex_RegDst != '0) &&
                     ((bus.ex_RegDst == bus.id_rs) || (bus.ex_RegDst == bus.id_rt));
  assign dmiss     = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;
  assign ifetch_ok = bus.ihit || pend_q;

  // Priority-ordered hazard resolution; first matching condition wins.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;
    pend_d      = pend_q;

    if (state_q == S_HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      halted = 1'b1;
    end else if (bus.mem_halt) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      state_d = S_HALTED;
    end else if (dmiss) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      memwb_flush = 1'b1;
      state_d     = S_MEM_WAIT;
      // A fetch landing during the freeze must survive until PC can advance.
      if (bus.ihit) begin
        pend_d = 1'b1;
      end
    end else begin
      state_d = S_RUN;
      if (redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (loaduse) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ifetch_ok) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end

    if (pc_en) begin
      pend_d = 1'b0;
    end
  end

  assign stall_inc = !pc_en && !halted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (stall_inc),
    .clr (1'b0),
    .q   (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (flush_inc),
    .clr (1'b0),
    .q   (bus.flush_count)
  );

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halted      = halted;

endmodule
